vending_machine_logic: RTL and testbench
========================================

# vending_machine_logic

Single-clock control core of the vending machine. It accepts a drink request with a 2-bit drink code, collects coin/note payments in units of 1, 5 and 10, dispenses the selected drink once the price is covered, and reports change. It sits between the front-panel/payment decoders and the dispenser actuator, and exposes a simple Moore-style status interface.

## Interface
- No parameters; prices are package constants.
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- request_i  in  1  customer request; held high for the whole transaction.
- drink_select_i  in  2  drink code: 00 FANTA, 01 PEPSI, 10 COLA, 11 CAMPA; sampled with request_i in IDLE.
- payment_ones_i  in  1  one unit inserted this cycle.
- payment_fives_i  in  1  five units inserted this cycle.
- payment_tens_i  in  1  ten units inserted this cycle.
- ready_o  out  1  machine idle, accepting requests.
- start_pay_o  out  1  payment phase active.
- drink_o  out  2  drink being dispensed; valid only with request_served_o, else 0.
- request_served_o  out  1  one-cycle dispense strobe.
- changes_o  out  5  change or refund amount; valid in SERVE/REFUND, else 0.

## Operation
- Prices: FANTA 15, PEPSI 20, COLA 20, CAMPA 10.
- States: IDLE, PAY, SERVE, REFUND. Outputs are a Moore decode of registered state plus registered drink/change.
- IDLE: ready_o=1. When request_i=1 at an edge, latch drink_select_i, clear credit, and go to PAY. Payment inputs are ignored.
- PAY: start_pay_o=1.
  - Each edge, incoming = 1·ones + 5·fives + 10·tens. All asserted denominations are summed, max 16 per cycle.
  - If request_i=0, go to REFUND. Latch change = credit; the incoming value that cycle is discarded.
  - Otherwise, if credit + incoming ≥ price, go to SERVE and latch change = credit + incoming − price.
  - Otherwise credit += incoming and stay in PAY.
- SERVE: request_served_o=1, drink_o = latched drink, changes_o = latched change, for exactly one cycle. Then go to IDLE unconditionally.
- REFUND: changes_o = credit, request_served_o=0, drink_o=0, for one cycle. Then go to IDLE.
- A request still high on return to IDLE starts a new transaction at the next edge.
- Width rules:
  - Credit register is 6 bits and never exceeds price−1 while in PAY.
  - Change ≤ 15 (price ≥ 10, per-cycle max 16), so it fits 5 bits with no saturation needed.
  - Refund ≤ 19.

## Timing
- Reset (rst_i=1 at an edge): state=IDLE, credit=0, latched drink=0, change=0. Outputs after that edge: ready_o=1, all others 0.
- Reset mid-transaction aborts without refund or dispense.
- Request sampled at edge N; start_pay_o high from N to the paying edge.
- Payment completing the price at edge M gives request_served_o high for M..M+1, then ready_o high from M+1.
- Exactly one of ready_o / start_pay_o / request_served_o / (REFUND) is active per cycle.

## Structure
- Package vending_pkg holds:
  - drink_e enum (FANTA, PEPSI, COLA, CAMPA).
  - state_e enum.
  - Price constants and a price_of(drink_e) function.
  - Denomination constants 1/5/10.
- Single module; no sub-module is warranted.

## Test plan
- Reset held 20 cycles then released → ready_o=1, start_pay_o=0, request_served_o=0, drink_o=0, changes_o=0.
- FANTA request; pay 1, 1, 10, 5 on consecutive cycles → start_pay_o for 4 cycles, then one cycle with request_served_o=1, drink_o=00, changes_o=2; then ready_o=1.
- CAMPA; pay 10 once → served next cycle, drink_o=11, changes_o=0.
- PEPSI; pay 5, then ones+fives+tens together (16) → served, changes_o=1.
- COLA; pay 10, then drop request_i → one REFUND cycle with changes_o=10, request_served_o=0; then IDLE.
- rst_i asserted during PAY with credit 12 → IDLE next cycle, no served pulse, changes_o=0.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and pricing for the vending machine control core.
package vending_pkg;

    typedef enum logic [1:0] {
        FANTA = 2'b00,
        PEPSI = 2'b01,
        COLA  = 2'b10,
        CAMPA = 2'b11
    } drink_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PAY    = 2'b01,
        ST_SERVE  = 2'b10,
        ST_REFUND = 2'b11
    } state_e;

    localparam logic [5:0] PRICE_FANTA = 6'd15;
    localparam logic [5:0] PRICE_PEPSI = 6'd20;
    localparam logic [5:0] PRICE_COLA  = 6'd20;
    localparam logic [5:0] PRICE_CAMPA = 6'd10;

    localparam logic [4:0] DENOM_ONE  = 5'd1;
    localparam logic [4:0] DENOM_FIVE = 5'd5;
    localparam logic [4:0] DENOM_TEN  = 5'd10;

    function automatic logic [5:0] price_of(drink_e d);
        logic [5:0] p;
        case (d)
            FANTA:   p = PRICE_FANTA;
            PEPSI:   p = PRICE_PEPSI;
            COLA:    p = PRICE_COLA;
            default: p = PRICE_CAMPA;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vending_machine_logic.sv
// Vending machine control FSM: takes a drink request, accumulates payment,
// dispenses once the price is covered and reports change or refund.
module vending_machine_logic
    import vending_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       request_i,
    input  logic [1:0] drink_select_i,
    input  logic       payment_ones_i,
    input  logic       payment_fives_i,
    input  logic       payment_tens_i,
    output logic       ready_o,
    output logic       start_pay_o,
    output logic [1:0] drink_o,
    output logic       request_served_o,
    output logic [4:0] changes_o
);

    state_e     state_q, state_d;
    drink_e     drink_q, drink_d;
    logic [5:0] credit_q, credit_d;
    logic [4:0] change_q, change_d;

    logic [4:0] incoming;
    logic [6:0] total;
    logic [6:0] price;

    // All asserted denominations in one cycle are summed (max 16).
    assign incoming = (payment_ones_i  ? DENOM_ONE  : 5'd0)
                    + (payment_fives_i ? DENOM_FIVE : 5'd0)
                    + (payment_tens_i  ? DENOM_TEN  : 5'd0);
    assign total    = {1'b0, credit_q} + {2'b00, incoming};
    assign price    = {1'b0, price_of(drink_q)};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            drink_q  <= FANTA;
            credit_q <= '0;
            change_q <= '0;
        end else begin
            state_q  <= state_d;
            drink_q  <= drink_d;
            credit_q <= credit_d;
            change_q <= change_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        drink_d  = drink_q;
        credit_d = credit_q;
        change_d = change_q;
        case (state_q)
            ST_IDLE: begin
                if (request_i) begin
                    drink_d  = drink_e'(drink_select_i);
                    credit_d = '0;
                    state_d  = ST_PAY;
                end
            end
            ST_PAY: begin
                // A withdrawn request discards this cycle's coins and refunds prior credit.
                if (!request_i) begin
                    change_d = 5'(credit_q);
                    state_d  = ST_REFUND;
                end else if (total >= price) begin
                    change_d = 5'(total - price);
                    state_d  = ST_SERVE;
                end else begin
                    credit_d = 6'(total);
                end
            end
            ST_SERVE:  state_d = ST_IDLE;
            ST_REFUND: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign ready_o          = (state_q == ST_IDLE);
    assign start_pay_o      = (state_q == ST_PAY);
    assign request_served_o = (state_q == ST_SERVE);
    assign drink_o          = (state_q == ST_SERVE) ? drink_q : 2'b00;
    assign changes_o        = (state_q == ST_SERVE || state_q == ST_REFUND) ? change_q : 5'd0;

endmodule

// File: tb/tb_vending_machine_logic.sv
// Randomized and directed checks of vending_machine_logic against a
// transaction-level model of the machine's pricing and payment rules.
module tb_vending_machine_logic;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       ones = 1'b0, fives = 1'b0, tens = 1'b0;
    logic       ready, start_pay, served;
    logic [1:0] drink;
    logic [4:0] changes;

    int passes = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    vending_machine_logic dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .request_i        (req),
        .drink_select_i   (sel),
        .payment_ones_i   (ones),
        .payment_fives_i  (fives),
        .payment_tens_i   (tens),
        .ready_o          (ready),
        .start_pay_o      (start_pay),
        .drink_o          (drink),
        .request_served_o (served),
        .changes_o        (changes)
    );

    always #5 clk = ~clk;

    // Transaction-level model: a customer is either paying or not, and a
    // finished transaction leaves one pending result (serve or refund) shown for a cycle.
    int price_tab [4] = '{15, 20, 20, 10};
    bit m_paying = 1'b0;
    int m_drink  = 0;
    int m_credit = 0;
    int m_result = 0;   // 0 none, 1 serve, 2 refund
    int m_amt    = 0;

    always @(posedge clk) begin
        int inc;
        inc = (ones ? 1 : 0) + (fives ? 5 : 0) + (tens ? 10 : 0);
        if (rst) begin
            m_paying = 1'b0;
            m_result = 0;
            m_drink  = 0;
            m_amt    = 0;
        end else if (m_result != 0) begin
            m_result = 0;
        end else if (!m_paying) begin
            if (req) begin
                m_paying = 1'b1;
                m_drink  = int'(sel);
                m_credit = 0;
            end
        end else if (!req) begin
            m_paying = 1'b0;
            m_result = 2;
            m_amt    = m_credit;
        end else if (m_credit + inc >= price_tab[m_drink]) begin
            m_paying = 1'b0;
            m_result = 1;
            m_amt    = m_credit + inc - price_tab[m_drink];
        end else begin
            m_credit = m_credit + inc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Single compare process against the model, on every cycle once reset has been seen.
    always @(negedge clk) begin
        if (chk_en) begin
            int exp_chg;
            exp_chg = (m_result != 0) ? m_amt : 0;
            check("ready",     int'(ready),     int'(!m_paying && m_result == 0));
            check("start_pay", int'(start_pay), int'(m_paying));
            check("served",    int'(served),    int'(m_result == 1));
            check("drink",     int'(drink),     (m_result == 1) ? m_drink : 0);
            check("changes",   int'(changes),   exp_chg);
        end
    end

    task automatic drive(input bit r, input bit q, input int s, input bit o, input bit f, input bit t);
        @(negedge clk);
        rst = r; req = q; sel = 2'(s); ones = o; fives = f; tens = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (20) drive(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        check("rst_ready",   int'(ready), 1);
        check("rst_changes", int'(changes), 0);
        check("rst_served",  int'(served), 0);

        // FANTA: 1,1,10,5 -> 17, change 2
        drive(0, 1, 0, 0, 0, 0);
        check("fanta_pay", int'(start_pay), 1);
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 1);
        check("fanta_still_pay", int'(start_pay), 1);
        drive(0, 1, 0, 0, 1, 0);
        check("fanta_served", int'(served), 1);
        check("fanta_drink",  int'(drink), 0);
        check("fanta_change", int'(changes), 2);
        drive(0, 0, 0, 0, 0, 0);
        check("fanta_ready", int'(ready), 1);

        // CAMPA: single ten, exact
        drive(0, 1, 3, 0, 0, 0);
        drive(0, 1, 3, 0, 0, 1);
        check("campa_served", int'(served), 1);
        check("campa_drink",  int'(drink), 3);
        check("campa_change", int'(changes), 0);
        drive(0, 0, 0, 0, 0, 0);

        // PEPSI: 5 then 16 -> change 1
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 1, 1, 1, 1);
        check("pepsi_served", int'(served), 1);
        check("pepsi_drink",  int'(drink), 1);
        check("pepsi_change", int'(changes), 1);
        drive(0, 0, 0, 0, 0, 0);

        // COLA: 10 then withdraw (coins that cycle discarded) -> refund 10
        drive(0, 1, 2, 0, 0, 0);
        drive(0, 1, 2, 0, 0, 1);
        drive(0, 0, 2, 0, 1, 0);
        check("cola_refund",      int'(changes), 10);
        check("cola_not_served",  int'(served), 0);
        check("cola_refund_idle", int'(ready), 0);
        drive(0, 0, 0, 0, 0, 0);
        check("cola_ready", int'(ready), 1);

        // Reset in PAY with credit 12
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1);
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 1, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        check("abort_ready",   int'(ready), 1);
        check("abort_served",  int'(served), 0);
        check("abort_changes", int'(changes), 0);
        drive(0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) != 0,
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
